// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and IDLE/EVAL/RESP sequencer in front of a 4-bit ALU
// Optional feature macro: ALU_SEQ_CHAIN_EN (chained operand a from last result low nibble).
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_tag,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic       cmd_chain,
`endif
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic [1:0] rsp_tag,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [7:0] alu_y,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef ALU_SEQ_CHAIN_EN
    localparam int EW = 14;
`else
    localparam int EW = 13;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    alu_a_q, alu_a_d;
    logic [3:0]    alu_b_q, alu_b_d;
    logic [2:0]    alu_s_q, alu_s_d;
    logic [1:0]    cur_tag_q, cur_tag_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_y_q, rsp_y_d;
    logic [1:0]    rsp_tag_q, rsp_tag_d;
    logic          busy_q, busy_d;
`ifdef ALU_SEQ_CHAIN_EN
    logic [3:0]    last_y_q, last_y_d;
`endif
    logic          push, pop;
    logic [EW-1:0] head, wr_entry;

    // Entry layout: [chain,] op[12:10], a[9:6], b[5:2], tag[1:0]
`ifdef ALU_SEQ_CHAIN_EN
    assign wr_entry = {cmd_chain, cmd_op, cmd_a, cmd_b, cmd_tag};
`else
    assign wr_entry = {cmd_op, cmd_a, cmd_b, cmd_tag};
`endif

    assign cmd_ready = rst_n && (count_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        cur_tag_d   = cur_tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_tag_d   = rsp_tag_q;
`ifdef ALU_SEQ_CHAIN_EN
        last_y_d    = last_y_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
`ifdef ALU_SEQ_CHAIN_EN
                    alu_a_d = head[13] ? last_y_q : head[9:6];
`else
                    alu_a_d = head[9:6];
`endif
                    alu_b_d   = head[5:2];
                    alu_s_d   = head[12:10];
                    cur_tag_d = head[1:0];
                    state_d   = S_EVAL;
                end
            end
            S_EVAL: begin
                rsp_y_d     = alu_y;
                rsp_tag_d   = cur_tag_q;
                rsp_valid_d = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
                last_y_d    = alu_y[3:0];
`endif
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_q != S_IDLE) || (count_q != '0);
    end

    // Storage array needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            cur_tag_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_tag_q   <= '0;
            busy_q      <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            last_y_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            cur_tag_q   <= cur_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_tag_q   <= rsp_tag_d;
            busy_q      <= busy_d;
`ifdef ALU_SEQ_CHAIN_EN
            last_y_q    <= last_y_d;
`endif
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_tag   = rsp_tag_q;
    assign busy      = busy_q;

endmodule
